mode_ctrl: RTL and testbench
============================

Name: mode_ctrl

Overview:
- Parametrised mode-select controller for the piano top level, the next generation of the 3-mode selector.
- Takes raw one-hot mode switches, synchronises and debounces them, and decides the active mode with an explicit fault state that recovers.
- Lets the playback engine lock the current mode mid-song.
- Drives the mode bus consumed by the free-play, auto-play and learning engines, plus the mode LEDs.

Parameters:
- NUM_MODES, 3, number of one-hot mode switches/modes (bit0 = free, bit1 = auto-play, bit2 = learning).
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required before a pattern is accepted; board build uses 1000000. Must be >= 1.
- BLINK_CYCLES, 8, half-period of the fault LED blink, in clk cycles. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sel_in  in  NUM_MODES  raw switch pattern, asynchronous to clk.
- lock  in  1  high means the current mode is frozen (auto-play or learning in progress).
- mode  out  NUM_MODES  accepted one-hot mode; all zero when no mode is accepted.
- mode_idx  out  clog2(NUM_MODES), minimum 1  binary index of mode; 0 when mode is zero.
- mode_valid  out  1  high in ACTIVE.
- mode_change  out  1  one-cycle pulse when mode takes a new non-zero value.
- fault  out  1  high in FAULT.
- mode_led  out  NUM_MODES  LED drive.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - All outputs are 0: mode, mode_idx, mode_valid, mode_change, fault, mode_led.
  - Synchroniser flops, candidate register, debounce counter and blink counter clear to 0.
- Rst has priority over all other inputs on every edge. Reset mid-debounce discards the candidate.
- Synchroniser: two flops on sel_in; their output is sel_s.
- Debounce:
  - Candidate register cand and counter cnt, which saturates at DEBOUNCE_CYCLES.
  - On an edge where sel_s != cand: cand <= sel_s, cnt <= 1.
  - Otherwise cnt increments until it saturates.
  - stable = (cnt == DEBOUNCE_CYCLES), combinational.
- Latency: sel_in constant from before edge 1 gives:
  - stable high after edge DEBOUNCE_CYCLES+2;
  - FSM outputs update at edge DEBOUNCE_CYCLES+3.
  - Any pattern held for fewer than DEBOUNCE_CYCLES synchronised samples is ignored.
- Pattern classes of cand: ZERO, ONEHOT (exactly one bit set), MULTI (two or more bits set).
- FSM transitions are evaluated only when stable=1; with stable=0 the state holds.
  - IDLE:
    - ONEHOT: go to ACTIVE, mode <= cand, pulse mode_change.
    - MULTI: go to FAULT.
    - ZERO: stay in IDLE.
  - ACTIVE with lock=1: hold the state and mode, ignoring every pattern.
  - ACTIVE with lock=0:
    - ONEHOT != mode: mode <= cand, pulse mode_change.
    - ONEHOT == mode: no action.
    - ZERO: stay in ACTIVE and retain mode (switch released).
    - MULTI: go to FAULT, mode <= 0.
  - FAULT (lock ignored):
    - ONEHOT: go to ACTIVE, mode <= cand, pulse mode_change.
    - ZERO: go to IDLE.
    - MULTI: stay in FAULT.
- Lock release: evaluation is level-based on stable, so a pattern accepted while locked takes effect on the first edge with lock=0. No re-debounce is needed.
- mode_change:
  - High for exactly one cycle, on the edge mode is loaded with a different non-zero value.
  - Never high when mode goes to 0.
- mode_idx is a registered update together with mode.
- mode_led:
  - ACTIVE: equals mode.
  - IDLE: 0.
  - FAULT: all ones, toggling every BLINK_CYCLES cycles. The blink counter starts at 0 on FAULT entry, with LEDs on first.
- No X on any output after reset; illegal state encodings recover to IDLE.

Decomposition:
- Shared package piano_pkg holds:
  - mode one-hot constants FREE_MODE = 001, AUTO_PLAY_MODE = 010, LEARNING_MODE = 100, NO_MODE = 000;
  - the FSM state enum IDLE/ACTIVE/FAULT;
  - the default DEBOUNCE_CYCLES for the board build.
- One sub-module, sel_debounce (parameters WIDTH, DEBOUNCE_CYCLES), containing the synchroniser, cand, cnt and stable. mode_ctrl holds the FSM, output registers and blink counter.

Test Plan (NUM_MODES=3, DEBOUNCE_CYCLES=4, BLINK_CYCLES=8):
- Reset, then sel_in=010 applied before edge 1 -> mode=010, mode_idx=1, mode_valid=1 and mode_change pulse at edge 7; all outputs 0 before that.
- In ACTIVE with mode=001: a 3-cycle glitch on sel_in to 100, then back to 001 -> no mode_change, mode stays 001.
- sel_in=011 held -> FAULT at edge 7: fault=1, mode=0, mode_led=111 for 8 cycles then 000 for 8. Then sel_in=100 -> ACTIVE, mode=100, one mode_change pulse.
- lock=1 with mode=010, sel_in changed to 001 and held 20 cycles -> mode stays 010. Drop lock -> mode=001 and mode_change on the next edge.
- ACTIVE mode=100, sel_in=000 -> mode retained and no pulse. rst asserted for 1 cycle mid-debounce of 001 -> all outputs 0 next edge, IDLE.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano top level: mode one-hot codes, the mode
// controller state encoding and the board-build debounce length.
package piano_pkg;

    localparam logic [2:0] NO_MODE        = 3'b000;
    localparam logic [2:0] FREE_MODE      = 3'b001;
    localparam logic [2:0] AUTO_PLAY_MODE = 3'b010;
    localparam logic [2:0] LEARNING_MODE  = 3'b100;

    // Roughly 10 ms of switch bounce at the board clock.
    localparam int BOARD_DEBOUNCE_CYCLES = 1000000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACTIVE = ST_ACTIVE,
        FAULT  = ST_FAULT
    } mode_state_e;

    typedef enum logic [1:0] {
        PAT_ZERO   = 2'd0,
        PAT_ONEHOT = 2'd1,
        PAT_MULTI  = 2'd2
    } pat_class_e;

endpackage

// File: rtl/sel_debounce.sv
// Two-flop synchroniser followed by a saturating debounce counter; stable
// means the candidate pattern has been seen DEBOUNCE_CYCLES samples in a row.
module sel_debounce #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sel_in,
    output logic [WIDTH-1:0] cand,
    output logic             stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sel_in;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cand   = cand_q;
    assign stable = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mode_ctrl.sv
// Mode-select controller: debounced one-hot switches drive an IDLE/ACTIVE/FAULT
// FSM that publishes the mode bus, its index, a change pulse and the mode LEDs.
module mode_ctrl
    import piano_pkg::*;
#(
    parameter int NUM_MODES       = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_CYCLES    = 8,
    localparam int IDX_W          = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_MODES-1:0] sel_in,
    input  logic                 lock,
    output logic [NUM_MODES-1:0] mode,
    output logic [IDX_W-1:0]     mode_idx,
    output logic                 mode_valid,
    output logic                 mode_change,
    output logic                 fault,
    output logic [NUM_MODES-1:0] mode_led
);

    localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_CYCLES - 1);

    function automatic pat_class_e classify(input logic [NUM_MODES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_MODES; i++) begin
            n += int'(v[i]);
        end
        if (n == 0)      return PAT_ZERO;
        else if (n == 1) return PAT_ONEHOT;
        else             return PAT_MULTI;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_MODES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic [NUM_MODES-1:0] cand;
    logic                 stable;

    sel_debounce #(
        .WIDTH          (NUM_MODES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .sel_in(sel_in),
        .cand  (cand),
        .stable(stable)
    );

    mode_state_e          state_q, state_d;
    logic [NUM_MODES-1:0] mode_q, mode_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 chg_q, chg_d;
    logic [BLK_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                 blink_on_q, blink_on_d;
    pat_class_e           pat;

    assign pat = classify(cand);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        chg_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable && pat == PAT_ONEHOT) begin
                    state_d = ACTIVE;
                    mode_d  = cand;
                    idx_d   = onehot_idx(cand);
                    chg_d   = 1'b1;
                end else if (stable && pat == PAT_MULTI) begin
                    state_d = FAULT;
                end
            end
            ACTIVE: begin
                // A released switch (ZERO) keeps the last mode on purpose.
                if (stable && !lock) begin
                    if (pat == PAT_ONEHOT && cand != mode_q) begin
                        mode_d = cand;
                        idx_d  = onehot_idx(cand);
                        chg_d  = 1'b1;
                    end else if (pat == PAT_MULTI) begin
                        state_d = FAULT;
                        mode_d  = '0;
                        idx_d   = '0;
                    end
                end
            end
            FAULT: begin
                if (stable && pat == PAT_ONEHOT) begin
                    state_d = ACTIVE;
                    mode_d  = cand;
                    idx_d   = onehot_idx(cand);
                    chg_d   = 1'b1;
                end else if (stable && pat == PAT_ZERO) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                mode_d  = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Blink phase restarts with LEDs lit on every entry into FAULT.
    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b0;
        if (state_d == FAULT) begin
            if (state_q != FAULT) begin
                blink_on_d = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_on_d = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
                blink_on_d  = blink_on_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            idx_q       <= '0;
            chg_q       <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            chg_q       <= chg_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    always_comb begin
        mode_led = '0;
        if (state_q == ACTIVE)     mode_led = mode_q;
        else if (state_q == FAULT) mode_led = {NUM_MODES{blink_on_q}};
    end

    assign mode        = mode_q;
    assign mode_idx    = idx_q;
    assign mode_valid  = (state_q == ACTIVE);
    assign fault       = (state_q == FAULT);
    assign mode_change = chg_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Bench for mode_ctrl: directed vector table plus randomized switch activity
// compared cycle by cycle against a sample-history reference model.
module tb_mode_ctrl;

    localparam int N  = 3;
    localparam int D  = 4;
    localparam int BL = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel_in;
    logic       lock;
    logic [2:0] mode;
    logic [1:0] mode_idx;
    logic       mode_valid, mode_change, fault;
    logic [2:0] mode_led;

    mode_ctrl #(.NUM_MODES(N), .DEBOUNCE_CYCLES(D), .BLINK_CYCLES(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_in     (sel_in),
        .lock       (lock),
        .mode       (mode),
        .mode_idx   (mode_idx),
        .mode_valid (mode_valid),
        .mode_change(mode_change),
        .fault      (fault),
        .mode_led   (mode_led)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [2:0] m);
        if (m == 3'b010) return 2'd1;
        if (m == 3'b100) return 2'd2;
        return 2'd0;
    endfunction

    // Reference model: 0 = idle, 1 = active, 2 = fault
    int         m_st;
    logic [2:0] m_mode;
    logic       m_chg;
    int         m_age;
    logic [2:0] in_hist[$];
    logic [2:0] samp_hist[$];

    task automatic model_edge();
        logic [2:0] samp, c;
        bit         stab;
        int         ones;
        bit         was_fault;
        if (rst) begin
            m_st = 0; m_mode = 3'b000; m_chg = 1'b0; m_age = 0;
            in_hist.delete();
            samp_hist.delete();
            return;
        end
        samp = (in_hist.size() >= 2) ? in_hist[in_hist.size() - 2] : 3'b000;
        stab = (samp_hist.size() >= D);
        c = stab ? samp_hist[samp_hist.size() - 1] : 3'b000;
        for (int i = 0; i < D && stab; i++)
            if (samp_hist[samp_hist.size() - 1 - i] != c) stab = 0;
        ones = int'(c[0]) + int'(c[1]) + int'(c[2]);
        was_fault = (m_st == 2);
        m_chg = 1'b0;
        if (stab) begin
            if (m_st == 0) begin
                if (ones == 1) begin m_st = 1; m_mode = c; m_chg = 1'b1; end
                else if (ones > 1) m_st = 2;
            end else if (m_st == 1) begin
                if (!lock && ones == 1 && c != m_mode) begin m_mode = c; m_chg = 1'b1; end
                else if (!lock && ones > 1) begin m_st = 2; m_mode = 3'b000; end
            end else begin
                if (ones == 1) begin m_st = 1; m_mode = c; m_chg = 1'b1; end
                else if (ones == 0) m_st = 0;
            end
        end
        if (m_st == 2) m_age = was_fault ? m_age + 1 : 0;
        samp_hist.push_back(samp);
        in_hist.push_back(sel_in);
        if (samp_hist.size() > D) void'(samp_hist.pop_front());
        if (in_hist.size() > 3) void'(in_hist.pop_front());
    endtask

    task automatic model_check();
        logic [2:0] e_led;
        e_led = 3'b000;
        if (m_st == 1) e_led = m_mode;
        else if (m_st == 2) e_led = (((m_age / BL) % 2) == 0) ? 3'b111 : 3'b000;
        chk("model_mode", mode, m_mode);
        chk("model_idx", mode_idx, idx_of(m_mode));
        chk("model_valid", mode_valid, m_st == 1);
        chk("model_fault", fault, m_st == 2);
        chk("model_chg", mode_change, m_chg);
        chk("model_led", mode_led, e_led);
    endtask

    task automatic cycle(input logic r, input logic [2:0] s, input logic l);
        rst = r; sel_in = s; lock = l;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] sel;
        logic       lock;
        int         hold;
        logic [2:0] e_mode;
        logic       e_chg;
        logic       e_valid;
        logic       e_fault;
        logic [2:0] e_led;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; sel_in = 3'b000; lock = 1'b0;
        m_st = 0; m_mode = 3'b000; m_chg = 1'b0; m_age = 0;
        //                rst sel    lk hold mode  chg vld flt led
        tbl.push_back('{1'b1, 3'b000, 1'b0, 2,  3'b000, 1'b0, 1'b0, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 3'b010, 1'b0, 6,  3'b000, 1'b0, 1'b0, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 3'b010, 1'b0, 1,  3'b010, 1'b1, 1'b1, 1'b0, 3'b010});
        tbl.push_back('{1'b0, 3'b010, 1'b0, 1,  3'b010, 1'b0, 1'b1, 1'b0, 3'b010});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 7,  3'b001, 1'b1, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{1'b0, 3'b100, 1'b0, 3,  3'b001, 1'b0, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 10, 3'b001, 1'b0, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{1'b0, 3'b011, 1'b0, 7,  3'b000, 1'b0, 1'b0, 1'b1, 3'b111});
        tbl.push_back('{1'b0, 3'b011, 1'b0, 7,  3'b000, 1'b0, 1'b0, 1'b1, 3'b111});
        tbl.push_back('{1'b0, 3'b011, 1'b0, 1,  3'b000, 1'b0, 1'b0, 1'b1, 3'b000});
        tbl.push_back('{1'b0, 3'b011, 1'b0, 8,  3'b000, 1'b0, 1'b0, 1'b1, 3'b111});
        tbl.push_back('{1'b0, 3'b100, 1'b0, 7,  3'b100, 1'b1, 1'b1, 1'b0, 3'b100});
        tbl.push_back('{1'b0, 3'b100, 1'b0, 1,  3'b100, 1'b0, 1'b1, 1'b0, 3'b100});
        tbl.push_back('{1'b0, 3'b010, 1'b0, 7,  3'b010, 1'b1, 1'b1, 1'b0, 3'b010});
        tbl.push_back('{1'b0, 3'b001, 1'b1, 20, 3'b010, 1'b0, 1'b1, 1'b0, 3'b010});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 1,  3'b001, 1'b1, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{1'b0, 3'b100, 1'b0, 7,  3'b100, 1'b1, 1'b1, 1'b0, 3'b100});
        tbl.push_back('{1'b0, 3'b000, 1'b0, 10, 3'b100, 1'b0, 1'b1, 1'b0, 3'b100});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 4,  3'b100, 1'b0, 1'b1, 1'b0, 3'b100});
        tbl.push_back('{1'b1, 3'b001, 1'b0, 1,  3'b000, 1'b0, 1'b0, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 6,  3'b000, 1'b0, 1'b0, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 1,  3'b001, 1'b1, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{1'b0, 3'b110, 1'b0, 7,  3'b000, 1'b0, 1'b0, 1'b1, 3'b111});
        tbl.push_back('{1'b0, 3'b000, 1'b1, 7,  3'b000, 1'b0, 1'b0, 1'b0, 3'b000});

        @(negedge clk);
        foreach (tbl[v]) begin
            for (int k = 0; k < tbl[v].hold; k++) cycle(tbl[v].rst, tbl[v].sel, tbl[v].lock);
            chk($sformatf("vec%0d_mode", v), mode, tbl[v].e_mode);
            chk($sformatf("vec%0d_idx", v), mode_idx, idx_of(tbl[v].e_mode));
            chk($sformatf("vec%0d_chg", v), mode_change, tbl[v].e_chg);
            chk($sformatf("vec%0d_valid", v), mode_valid, tbl[v].e_valid);
            chk($sformatf("vec%0d_fault", v), fault, tbl[v].e_fault);
            chk($sformatf("vec%0d_led", v), mode_led, tbl[v].e_led);
        end

        // Hand sequence: single-cycle pulse width and reset priority over a stable pattern.
        cycle(1'b1, 3'b100, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b0, 3'b100, 1'b0);
        chk("seq_pre_chg", mode_change, 1'b0);
        cycle(1'b0, 3'b100, 1'b0);
        chk("seq_pulse", mode_change, 1'b1);
        chk("seq_idx", mode_idx, 2'd2);
        cycle(1'b0, 3'b100, 1'b0);
        chk("seq_pulse_end", mode_change, 1'b0);
        cycle(1'b1, 3'b100, 1'b0);
        chk("seq_rst_mode", mode, 3'b000);
        chk("seq_rst_valid", mode_valid, 1'b0);

        // Randomized switch activity against the model.
        for (int t = 0; t < 400; t++) begin
            int         r, hold;
            logic [2:0] s;
            logic       l, rr;
            r = $urandom_range(0, 9);
            if (r < 6)      s = 3'b001 << $urandom_range(0, 2);
            else if (r < 8) s = 3'b000;
            else            s = 3'($urandom_range(0, 7));
            l    = ($urandom_range(0, 3) == 0);
            rr   = ($urandom_range(0, 49) == 0);
            hold = $urandom_range(1, 12);
            for (int k = 0; k < hold; k++) cycle(rr && k == 0, s, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
